// File: rtl/datapath_seq.sv
// datapath_seq: register file plus A/B/C/status datapath with a shifter and a
// 2-bit ALU. A single start pulse runs a fixed sequence:
// LOADA -> LOADB -> EXEC -> WB. After that, done pulses for one cycle.
module datapath_seq #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int RW = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [RW-1:0]          rn,
    input  logic [RW-1:0]          rm,
    input  logic [RW-1:0]          rd,
    input  logic [1:0]             alu_op,
    input  logic [1:0]             shift,
    input  logic                   a_zero,
    input  logic                   b_imm,
    input  logic [WIDTH-1:0]       imm,
    input  logic                   wb_en,
    input  logic                   set_flags,
    input  logic                   wr_en,
    input  logic [RW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic [2:0]             status,
    output logic [NREGS*WIDTH-1:0] reg_out
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOADA = 3'd1;
    localparam logic [2:0] S_LOADB = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam int MSB = WIDTH - 1;

    logic [2:0]                  state;
    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]            a_q, b_q, c_q;
    logic [2:0]                  status_q;
    logic                        done_q;

    // Operation fields, captured at start so the decoder may move on.
    logic [RW-1:0]    op_rn, op_rm, op_rd;
    logic [1:0]       op_alu, op_shift;
    logic             op_a_zero, op_b_imm, op_wb_en, op_set_flags;
    logic [WIDTH-1:0] op_imm;

    logic [WIDTH-1:0] ain, b_sh, bin, alu_res;
    logic             alu_v;

    // Operand select, one-bit shifter and ALU with signed-overflow detect.
    always_comb begin
        ain = op_a_zero ? '0 : a_q;
        case (op_shift)
            2'b01:   b_sh = {b_q[MSB-1:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[MSB:1]};
            2'b11:   b_sh = {b_q[MSB], b_q[MSB:1]};
            default: b_sh = b_q;
        endcase
        bin     = op_b_imm ? op_imm : b_sh;
        alu_res = '0;
        alu_v   = 1'b0;
        case (op_alu)
            2'b00: begin
                alu_res = ain + bin;
                alu_v   = (ain[MSB] == bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            end
            2'b01: begin
                alu_res = ain + ~bin + WIDTH'(1);
                alu_v   = (ain[MSB] != bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            end
            2'b10:   alu_res = ain & bin;
            default: alu_res = ~bin;
        endcase
    end

    // Sequencer plus the A/B/C/status and operation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            status_q     <= '0;
            op_rn        <= '0;
            op_rm        <= '0;
            op_rd        <= '0;
            op_alu       <= '0;
            op_shift     <= '0;
            op_a_zero    <= 1'b0;
            op_b_imm     <= 1'b0;
            op_imm       <= '0;
            op_wb_en     <= 1'b0;
            op_set_flags <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_rn        <= rn;
                    op_rm        <= rm;
                    op_rd        <= rd;
                    op_alu       <= alu_op;
                    op_shift     <= shift;
                    op_a_zero    <= a_zero;
                    op_b_imm     <= b_imm;
                    op_imm       <= imm;
                    op_wb_en     <= wb_en;
                    op_set_flags <= set_flags;
                    state        <= S_LOADA;
                end
                S_LOADA: begin
                    a_q   <= regs[op_rn];
                    state <= S_LOADB;
                end
                S_LOADB: begin
                    b_q   <= regs[op_rm];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    c_q <= alu_res;
                    if (op_set_flags)
                        status_q <= {(alu_res == '0), alu_v, alu_res[MSB]};
                    state <= S_WB;
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Register file: write-back from WB, or the direct port while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (state == S_WB && op_wb_en)
            regs[op_rd] <= c_q;
        else if (state == S_IDLE && wr_en)
            regs[wr_addr] <= wr_data;
    end

    // done covers exactly the idle cycle that follows WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= (state == S_WB);
    end

    assign busy    = (state != S_IDLE);
    assign done    = done_q;
    assign result  = c_q;
    assign status  = status_q;
    assign reg_out = regs;
endmodule
